// File: rtl/wallace_pkg.sv
// Shared helpers for the Booth/Wallace multiplier: partial-product count,
// reduction-tree sizing, Booth digit encoding and the sign-extension constant.
package wallace_pkg;

    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_sel_t;

    localparam booth_sel_t BOOTH_ZERO = 3'b000;
    localparam booth_sel_t BOOTH_POS1 = 3'b010;
    localparam booth_sel_t BOOTH_POS2 = 3'b001;
    localparam booth_sel_t BOOTH_NEG1 = 3'b110;
    localparam booth_sel_t BOOTH_NEG2 = 3'b101;

    function automatic int num_pp(input int width);
        return width / 2 + 1;
    endfunction

    // Row count after lvl levels of 3:2 reduction starting from n rows.
    function automatic int rows_after(input int n, input int lvl);
        int r;
        r = n;
        for (int i = 0; i < lvl; i++) begin
            if (r > 2) r = 2 * (r / 3) + r % 3;
        end
        return r;
    endfunction

    function automatic int tree_levels(input int n);
        int r;
        int l;
        r = n;
        l = 0;
        while (r > 2) begin
            r = 2 * (r / 3) + r % 3;
            l++;
        end
        return l;
    endfunction

    // Triplet is {b[2i+1], b[2i], b[2i-1]}.
    function automatic booth_sel_t booth_encode(input logic [2:0] trip);
        case (trip)
            3'b001, 3'b010: return BOOTH_POS1;
            3'b011:         return BOOTH_POS2;
            3'b100:         return BOOTH_NEG2;
            3'b101, 3'b110: return BOOTH_NEG1;
            default:        return BOOTH_ZERO;
        endcase
    endfunction

    // Each row's sign bit is inverted in place; this constant removes the
    // 2^(width+1+2i) that the inversion adds for every partial product.
    function automatic logic [127:0] sext_const(input int width);
        logic [127:0] k;
        k = '0;
        for (int i = 0; i < width / 2 + 1; i++) begin
            k = k - (128'd1 << (width + 1 + 2 * i));
        end
        return k;
    endfunction

endpackage

// File: rtl/three_to_two.sv
// Full-adder cell used as the 3:2 counter of the reduction tree.
module three_to_two (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/wallace_mul_pipe.sv
// Pipelined radix-4 Booth multiplier with a Wallace carry-save tree, an
// optional register in the middle of the tree and a registered final adder.
module wallace_mul_pipe
    import wallace_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int PIPE_MID = 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               sgn,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p
);
    localparam int PW      = 2 * WIDTH;
    localparam int NPP     = num_pp(WIDTH);
    localparam int NROWS   = NPP + 2;
    localparam int LEVELS  = tree_levels(NROWS);
    localparam int MID_LVL = LEVELS / 2;
    localparam logic [127:0] SEXT_ALL = sext_const(WIDTH);
    localparam logic [PW-1:0] SEXT_K  = SEXT_ALL[PW-1:0];

    logic                  adv;
    logic                  vld_p1;
    logic signed [WIDTH:0] a_ext;
    logic [WIDTH+2:0]      b_ext;
    logic [NPP-1:0]        neg_bits;
    logic [PW-1:0]         neg_row;
    logic [PW-1:0]         sum;
    logic [PW-1:0]         tree    [0:LEVELS][0:NROWS-1];
    logic [PW-1:0]         lvl_in  [0:LEVELS-1][0:NROWS-1];
    logic [PW-1:0]         rows_p1 [0:NROWS-1];

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage 0: Booth partial products, b carries an implicit zero below bit 0
    assign a_ext = {sgn & a[WIDTH-1], a};
    assign b_ext = {{2{sgn & b[WIDTH-1]}}, b, 1'b0};

    for (genvar i = 0; i < NPP; i++) begin : g_pp
        booth_sel_t       sel;
        logic [WIDTH+1:0] mag;
        logic [WIDTH+1:0] bits;
        assign sel         = booth_encode(b_ext[2*i+2 -: 3]);
        assign mag         = sel.two ? {a_ext, 1'b0} : (sel.one ? {a_ext[WIDTH], a_ext} : '0);
        assign bits        = sel.neg ? ~mag : mag;
        assign neg_bits[i] = sel.neg;
        assign tree[0][i]  = PW'({~bits[WIDTH+1], bits[WIDTH:0]}) << (2 * i);
    end

    always_comb begin
        neg_row = '0;
        for (int i = 0; i < NPP; i++) begin
            neg_row[2*i] = neg_bits[i];
        end
    end

    assign tree[0][NPP]     = neg_row;
    assign tree[0][NPP + 1] = SEXT_K;

    // Stage 1 boundary: rows leaving level MID_LVL, registered or passed through
    if (PIPE_MID != 0) begin : g_mid_reg
        always_ff @(posedge clk) begin
            if (!resetn) begin
                vld_p1 <= 1'b0;
                for (int r = 0; r < NROWS; r++) rows_p1[r] <= '0;
            end else if (adv) begin
                vld_p1 <= in_valid;
                for (int r = 0; r < NROWS; r++) rows_p1[r] <= tree[MID_LVL][r];
            end
        end
    end else begin : g_mid_wire
        assign vld_p1 = in_valid;
        for (genvar r = 0; r < NROWS; r++) begin : g_row
            assign rows_p1[r] = tree[MID_LVL][r];
        end
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_src
        for (genvar r = 0; r < NROWS; r++) begin : g_row
            if (l == MID_LVL) begin : g_from_mid
                assign lvl_in[l][r] = rows_p1[r];
            end else begin : g_from_tree
                assign lvl_in[l][r] = tree[l][r];
            end
        end
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int RI = rows_after(NROWS, l);
        localparam int RO = rows_after(NROWS, l + 1);
        localparam int NG = RI / 3;

        for (genvar g = 0; g < NG; g++) begin : g_grp
            logic [PW-1:0] s;
            logic [PW-1:0] cy;
            logic          unused_cy_top;
            for (genvar c = 0; c < PW; c++) begin : g_col
                three_to_two u_csa (
                    .a  (lvl_in[l][3*g][c]),
                    .b  (lvl_in[l][3*g+1][c]),
                    .ci (lvl_in[l][3*g+2][c]),
                    .s  (s[c]),
                    .co (cy[c])
                );
            end
            assign tree[l+1][2*g]   = s;
            assign tree[l+1][2*g+1] = {cy[PW-2:0], 1'b0};
            assign unused_cy_top    = cy[PW-1];
        end

        // Rows not consumed by a counter move down unchanged.
        for (genvar r = 2 * NG; r < NROWS; r++) begin : g_pass
            if (r < RO) begin : g_keep
                assign tree[l+1][r] = lvl_in[l][r + NG];
            end else begin : g_zero
                assign tree[l+1][r] = '0;
            end
        end
    end

    assign sum = tree[LEVELS][0] + tree[LEVELS][1];

    // Stage 2 boundary: output register, p only reloads on a valid product
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            p         <= '0;
        end else if (adv) begin
            out_valid <= vld_p1;
            if (vld_p1) p <= sum;
        end
    end

endmodule
